// File: rtl/mem_req_arbiter_rr.sv
// Two-requester round-robin arbiter sharing one 16B memory port, with in-order response steering.
// Optional build macro MEM_ARB_FIXED_PRIO_EN selects strict fixed priority (requester 0 always wins).
module mem_req_arbiter_rr #(
    parameter int p_max_outstanding = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [174:0] req0_msg,
    input  logic         req0_val,
    output logic         req0_rdy,
    input  logic [174:0] req1_msg,
    input  logic         req1_val,
    output logic         req1_rdy,
    output logic [144:0] resp0_msg,
    output logic         resp0_val,
    input  logic         resp0_rdy,
    output logic [144:0] resp1_msg,
    output logic         resp1_val,
    input  logic         resp1_rdy,
    output logic [174:0] memreq_msg,
    output logic         memreq_val,
    input  logic         memreq_rdy,
    input  logic [144:0] memresp_msg,
    input  logic         memresp_val,
    output logic         memresp_rdy
);
    localparam int CW = $clog2(p_max_outstanding + 1);
    localparam int PW = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(p_max_outstanding);
    localparam logic [PW-1:0] LAST_PTR = PW'(p_max_outstanding - 1);

    // Handshake: a transfer fires on a port in any cycle where its val and rdy are both high;
    // reset forces every val and rdy low so nothing transfers while it is asserted.

    logic [p_max_outstanding-1:0] ids;
    logic [PW-1:0]                head_ptr;
    logic [PW-1:0]                tail_ptr;
    logic [CW-1:0]                count;
    logic                         full;
    logic                         empty;
    logic                         any_req;
    logic                         winner;
    logic                         head_id;
    logic                         req_fire;
    logic                         resp_fire;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign any_req = req0_val | req1_val;
    assign head_id = ids[head_ptr];

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = !req0_val && req1_val;
    end
`else
    logic prio;

    always_comb begin
        winner = 1'b0;
        if (req0_val && req1_val) begin
            winner = prio;
        end else begin
            winner = req1_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (req_fire) begin
            prio <= !winner;
        end
    end
`endif

    // Request side: full is taken from the registered count, so a same-cycle pop cannot unblock a push.
    assign memreq_msg = winner ? req1_msg : req0_msg;
    assign memreq_val = !reset && any_req && !full;
    assign req0_rdy   = !reset && !winner && memreq_rdy && !full && any_req;
    assign req1_rdy   = !reset && winner && memreq_rdy && !full && any_req;
    assign req_fire   = memreq_val && memreq_rdy;

    // Response side never looks at the request ports, keeping resp*_rdy off the req*_rdy path.
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign resp0_val   = !reset && memresp_val && !empty && !head_id;
    assign resp1_val   = !reset && memresp_val && !empty && head_id;
    assign memresp_rdy = !reset && !empty && (head_id ? resp1_rdy : resp0_rdy);
    assign resp_fire   = memresp_val && memresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (req_fire) begin
                ids[tail_ptr] <= winner;
                tail_ptr      <= next_ptr(tail_ptr);
            end
            if (resp_fire) begin
                head_ptr <= next_ptr(head_ptr);
            end
            case ({req_fire, resp_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
